// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multicycle ARM-subset controller.
//   - state_e      : FSM state encoding (also exported on the debug State port)
//   - Cond*        : instruction condition-field encodings
//   - Cmd*         : data-processing cmd field values (Funct[4:1])
//   - Op*          : instruction class field (Op[1:0])
//   - Alu*         : ALUControl codes
//   - SrcA*/SrcB*/Res* : datapath mux select codes
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRd    = 4'd3,
        StMemWb    = 4'd4,
        StMemWr    = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } state_e;

    // Condition field encodings
    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondCs = 4'b0010;
    localparam logic [3:0] CondCc = 4'b0011;
    localparam logic [3:0] CondMi = 4'b0100;
    localparam logic [3:0] CondPl = 4'b0101;
    localparam logic [3:0] CondVs = 4'b0110;
    localparam logic [3:0] CondVc = 4'b0111;
    localparam logic [3:0] CondHi = 4'b1000;
    localparam logic [3:0] CondLs = 4'b1001;
    localparam logic [3:0] CondGe = 4'b1010;
    localparam logic [3:0] CondLt = 4'b1011;
    localparam logic [3:0] CondGt = 4'b1100;
    localparam logic [3:0] CondLe = 4'b1101;
    localparam logic [3:0] CondAl = 4'b1110;
    localparam logic [3:0] CondNv = 4'b1111;

    // Data-processing cmd field values
    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdOrr = 4'b1100;

    // Instruction classes
    localparam logic [1:0] OpDp     = 2'b00;
    localparam logic [1:0] OpMem    = 2'b01;
    localparam logic [1:0] OpBranch = 2'b10;
    localparam logic [1:0] OpNone   = 2'b11;

    // ALUControl codes
    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluOrr = 2'b11;

    // ALU operand A select
    localparam logic [1:0] SrcAReg = 2'b00;
    localparam logic [1:0] SrcAPc  = 2'b01;

    // ALU operand B select
    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // Result select: registered ALU output, memory data, or live ALU result
    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResData   = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    // Map a data-processing cmd to its ALU operation; unsupported cmds add.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        logic [1:0] code;
        unique case (cmd)
            CmdAdd:  code = AluAdd;
            CmdSub:  code = AluSub;
            CmdAnd:  code = AluAnd;
            CmdOrr:  code = AluOrr;
            default: code = AluAdd;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// cond_unit: architectural NZCV flag register and condition evaluation.
//   clk      in  : clock, rising edge
//   reset    in  : asynchronous active-low reset, clears the flags
//   Cond     in  : instruction condition field
//   ALUFlags in  : {N,Z,C,V} produced by the ALU this cycle
//   FlagW    in  : [1] loads N,Z; [0] loads C,V at the next rising edge
//   CondEx   out : condition passes against the registered flags
//   Flags    out : registered {N,Z,C,V}
module cond_unit
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;

    always_comb begin
        flags_d = flags_q;
        if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
        if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign {n, z, c, v} = flags_q;
    assign Flags        = flags_q;

    // Evaluated from the registered flags only: an instruction never sees
    // flags that are being written in the same cycle.
    always_comb begin
        CondEx = 1'b0;
        unique case (Cond)
            CondEq: CondEx = z;
            CondNe: CondEx = ~z;
            CondCs: CondEx = c;
            CondCc: CondEx = ~c;
            CondMi: CondEx = n;
            CondPl: CondEx = ~n;
            CondVs: CondEx = v;
            CondVc: CondEx = ~v;
            CondHi: CondEx = c & ~z;
            CondLs: CondEx = ~(c & ~z);
            CondGe: CondEx = (n == v);
            CondLt: CondEx = (n != v);
            CondGt: CondEx = ~z & (n == v);
            CondLe: CondEx = ~(~z & (n == v));
            CondAl: CondEx = 1'b1;
            CondNv: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the ARM-subset core.
// Sequences the shared datapath through fetch, decode and execute states,
// squashes instructions whose condition fails, and stalls on MemReady.
//   clk, reset           : clock (rising edge), async active-low reset
//   Cond, Op, Funct, Rd  : instruction fields from the instruction register
//   ALUFlags             : {N,Z,C,V} from the ALU this cycle
//   MemReady             : memory completes the current access
//   PCWrite .. AdrSrc    : datapath write enables and address select
//   ALUSrcA/B, ResultSrc : datapath mux selects
//   ImmSrc, RegSrc       : immediate-extend and register-address selects
//   ALUControl           : ALU operation
//   State                : current FSM state (debug)
//   Flags                : registered {N,Z,C,V}
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] State,
    output logic [3:0] Flags
);

    state_e     state_q, state_d;
    logic       cond_ex;
    logic [1:0] flag_w;
    logic [3:0] cmd;
    logic       is_exec;
    logic       pc_write, ir_write, reg_write, mem_write;

    assign cmd     = Funct[4:1];
    assign is_exec = (state_q == StExecuteR) || (state_q == StExecuteI);

    // S bit set: N,Z always load; C,V only for arithmetic ops
    always_comb begin
        flag_w    = 2'b00;
        flag_w[1] = is_exec & Funct[0];
        flag_w[0] = is_exec & Funct[0] & ((cmd == CmdAdd) || (cmd == CmdSub));
    end

    cond_unit u_cond_unit (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (flag_w),
        .CondEx   (cond_ex),
        .Flags    (Flags)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (MemReady) state_d = StDecode;
            end
            StDecode: begin
                if (!cond_ex) begin
                    state_d = StFetch;
                end else begin
                    unique case (Op)
                        OpMem:    state_d = StMemAdr;
                        OpDp:     state_d = Funct[5] ? StExecuteI : StExecuteR;
                        OpBranch: state_d = StBranch;
                        OpNone:   state_d = StFetch;
                        default:  state_d = StFetch;
                    endcase
                end
            end
            StMemAdr:   state_d = Funct[0] ? StMemRd : StMemWr;
            StMemRd: begin
                if (MemReady) state_d = StMemWb;
            end
            StMemWr: begin
                if (MemReady) state_d = StFetch;
            end
            StMemWb:    state_d = StFetch;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            // Unused encodings recover to fetch
            default:    state_d = StFetch;
        endcase
    end

    // Moore outputs
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SrcAReg;
        ALUSrcB   = SrcBReg;
        ResultSrc = ResAluOut;
        case (state_q)
            StFetch: begin
                ALUSrcA   = SrcAPc;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAlu;
                // PC+4 and the instruction latch only once memory delivers
                ir_write  = MemReady;
                pc_write  = MemReady;
            end
            StDecode: begin
                ALUSrcA   = SrcAPc;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAlu;
            end
            StMemAdr, StExecuteI: begin
                ALUSrcB = SrcBImm;
            end
            StExecuteR: begin
                ALUSrcB = SrcBReg;
            end
            StMemRd: begin
                AdrSrc = 1'b1;
            end
            StMemWr: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            StMemWb, StAluWb: begin
                ResultSrc = (state_q == StMemWb) ? ResData : ResAluOut;
                // Writes to r15 redirect the PC instead of the register file
                if (Rd == 4'b1111) begin
                    pc_write = 1'b1;
                end else begin
                    reg_write = 1'b1;
                end
            end
            StBranch: begin
                ALUSrcB   = SrcBImm;
                ResultSrc = ResAlu;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset gates the enables combinationally so nothing is written while
    // reset is held, even though FETCH would otherwise follow MemReady.
    assign PCWrite  = pc_write & reset;
    assign IRWrite  = ir_write & reset;
    assign RegWrite = reg_write & reset;
    assign MemWrite = mem_write & reset;

    assign ALUControl = is_exec ? alu_decode(cmd) : AluAdd;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == OpBranch, Op == OpMem};
    assign State      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: self-checking bench for mc_controller. An instruction-level
// reference model plans each instruction's state path and stall cycles, and
// predicts outputs and flags every cycle.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       MemReady;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0] State;
    logic [3:0] Flags;

    int checks   = 0;
    int failures = 0;

    logic [3:0] flags_m;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .State      (State),
        .Flags      (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ARM conditions come in pairs: even code is the test, odd is its inverse.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !r : r;
    endfunction

    // Expected {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ALUSrcA,ALUSrcB,
    //           ResultSrc,ImmSrc,RegSrc,ALUControl} for state number st.
    function automatic logic [16:0] exp_out(input int st, input logic mr, input logic [1:0] op,
                                            input logic [5:0] funct, input logic [3:0] rd);
        logic pcw, irw, rw, mw, adr;
        logic [1:0] asa, asb, rs, alc;
        pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0;
        asa = 0; asb = 0; rs = 0; alc = 0;
        case (st)
            0: begin asa = 1; asb = 2; rs = 2; irw = mr; pcw = mr; end
            1: begin asa = 1; asb = 2; rs = 2; end
            2, 7: asb = 1;
            3: adr = 1;
            5: begin adr = 1; mw = 1; end
            4, 8: begin
                rs = (st == 4) ? 2'd1 : 2'd0;
                if (rd == 4'd15) pcw = 1; else rw = 1;
            end
            9: begin asb = 1; rs = 2; pcw = 1; end
            default: ;
        endcase
        if (st == 6 || st == 7) begin
            case (funct[4:1])
                4'd4:  alc = 0;
                4'd2:  alc = 1;
                4'd0:  alc = 2;
                4'd12: alc = 3;
                default: alc = 0;
            endcase
        end
        return {pcw, irw, rw, mw, adr, asa, asb, rs, op, op == 2'b10, op == 2'b01, alc};
    endfunction

    // Run one instruction starting in FETCH; the model decides the path.
    task automatic run_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input logic [3:0] af, input int fstall,
                             input int mstall, output int ir_cnt, output int rw_cnt);
        int path[$];
        int st, stall;
        logic [3:0] nf;
        path.push_back(0);
        path.push_back(1);
        if (cond_ok(cond, flags_m)) begin
            case (op)
                2'b01: begin
                    path.push_back(2);
                    if (funct[0]) begin path.push_back(3); path.push_back(4); end
                    else path.push_back(5);
                end
                2'b00: begin path.push_back(funct[5] ? 7 : 6); path.push_back(8); end
                2'b10: path.push_back(9);
                default: ;
            endcase
        end
        nf = flags_m;
        if (funct[0]) begin
            nf[3:2] = af[3:2];
            if (funct[4:1] == 4'd4 || funct[4:1] == 4'd2) nf[1:0] = af[1:0];
        end
        ir_cnt = 0;
        rw_cnt = 0;
        foreach (path[i]) begin
            st = path[i];
            stall = (st == 0) ? fstall : ((st == 3 || st == 5) ? mstall : 0);
            for (int k = 0; k <= stall; k++) begin
                Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = af;
                MemReady = (st == 0 || st == 3 || st == 5) ? (k == stall) : 1'($urandom);
                #1;
                check("state", 32'(State), st);
                check("outputs", 32'({PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                                      ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl}),
                      32'(exp_out(st, MemReady, op, funct, rd)));
                check("flags", 32'(Flags), 32'(flags_m));
                ir_cnt += int'(IRWrite);
                rw_cnt += int'(RegWrite);
                @(posedge clk);
                #1;
            end
            if (st == 6 || st == 7) flags_m = nf;
        end
    endtask

    initial begin
        int ir, rw;
        logic [3:0] rc;
        flags_m  = 4'b0000;
        reset    = 1'b0;
        Cond     = 4'hE;
        Op       = 2'b00;
        Funct    = 6'd0;
        Rd       = 4'd0;
        ALUFlags = 4'd0;
        MemReady = 1'b1;

        // Reset state with enables held off despite MemReady
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_state", 32'(State), 0);
        check("rst_flags", 32'(Flags), 0);
        check("rst_we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 0);
        reset = 1'b1;

        // ADDS sets all flags; SUB without S leaves them
        run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0110, 0, 0, ir, rw);
        check("adds_flags", 32'(Flags), 32'h6);
        run_instr(4'hE, 2'b00, 6'b000100, 4'd2, 4'b1001, 0, 0, ir, rw);
        check("sub_noS_flags", 32'(Flags), 32'h6);

        // Reset in the middle of an LDR (stalled in MEMRD)
        Cond = 4'hE; Op = 2'b01; Funct = 6'b000001; Rd = 4'd2; MemReady = 1'b1;
        #1 check("ldr_mid_s0", 32'(State), 0);
        @(posedge clk); #1 check("ldr_mid_s1", 32'(State), 1);
        @(posedge clk); #1 check("ldr_mid_s2", 32'(State), 2);
        @(posedge clk); MemReady = 1'b0;
        #1 check("ldr_mid_s3", 32'(State), 3);
        reset = 1'b0;
        MemReady = 1'b1;
        #1;
        check("midrst_state", 32'(State), 0);
        check("midrst_flags", 32'(Flags), 0);
        check("midrst_we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 0);
        @(posedge clk);
        #1;
        check("midrst_hold", 32'(State), 0);
        reset = 1'b1;
        flags_m = 4'b0000;

        // EQ branch taken (Z=1), then squashed (Z=0)
        run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0100, 0, 0, ir, rw);
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0, ir, rw);
        run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0000, 0, 0, ir, rw);
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0, ir, rw);

        // LDR with 2 fetch stalls and 3 MEMRD stalls
        run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, 2, 3, ir, rw);
        check("ldr_irwrite_pulses", 32'(ir), 1);
        check("ldr_regwrite_cycles", 32'(rw), 1);

        // Data-processing write to PC
        run_instr(4'hE, 2'b00, 6'b101000, 4'd15, 4'b0000, 0, 0, ir, rw);
        check("pcwr_regwrite", 32'(rw), 0);

        // Condition sweep: load every flag state, then try every condition
        for (int f = 0; f < 16; f++) begin
            run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'(f), 0, 0, ir, rw);
            check("sweep_flags", 32'(Flags), 32'(f));
            for (int c = 0; c < 16; c++) begin
                run_instr(4'(c), 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0, ir, rw);
            end
        end

        // Random instructions with random stalls
        for (int t = 0; t < 200; t++) begin
            rc = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE;
            run_instr(rc, 2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2), ir, rw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the ARM-subset core. It sequences the shared datapath (one ALU, one memory port, register file, PC) through fetch, decode and execute states. It holds the architectural NZCV flags and evaluates each instruction's condition field to squash failed instructions. A memory-ready handshake stalls fetch and data accesses.

## Interface
- No parameters; state encoding and ALU codes are fixed constants in the package.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `Cond` in 4: instruction bits [31:28].
- `Op` in 2: instruction bits [27:26].
- `Funct` in 6: instruction bits [25:20]. [5]=I, [4:1]=cmd, [0]=S or L.
- `Rd` in 4: destination register.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU, current cycle.
- `MemReady` in 1: memory completes the access this cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, `AdrSrc` out 1 each.
- `ALUSrcA`, `ALUSrcB`, `ResultSrc`, `ImmSrc`, `RegSrc`, `ALUControl` out 2 each.
- `State` out 4: current state, for debug.
- `Flags` out 4: registered {N,Z,C,V}.

## Operation
- **States:**
  - FETCH=0
  - DECODE=1
  - MEMADR=2
  - MEMRD=3
  - MEMWB=4
  - MEMWR=5
  - EXECUTER=6
  - EXECUTEI=7
  - ALUWB=8
  - BRANCH=9
  - Encodings 10–15 are illegal and go to FETCH.
- **Transitions:**
  - FETCH→DECODE when MemReady, else hold.
  - DECODE: CondEx=0→FETCH (instruction squashed). Otherwise Op=01→MEMADR; Op=00 with Funct[5]=0→EXECUTER; Op=00 with Funct[5]=1→EXECUTEI; Op=10→BRANCH; Op=11→FETCH (no effect).
  - MEMADR→MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD→MEMWB when MemReady, else hold.
  - MEMWR→FETCH when MemReady, else hold.
  - MEMWB, ALUWB, BRANCH→FETCH.
  - EXECUTER, EXECUTEI→ALUWB.
- **Condition evaluation:** CondEx is computed from the registered Flags.
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~(C&~Z).
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT ~Z&(N==V); 1101 LE its complement.
  - 1110 AL 1; 1111 CondEx=0 (never).
- **Moore outputs by state** (unlisted outputs are 0):
  - FETCH: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=MemReady, PCWrite=MemReady.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR, EXECUTEI: ALUSrcB=01.
  - EXECUTER: ALUSrcB=00.
  - MEMRD: AdrSrc=1.
  - MEMWR: AdrSrc=1, MemWrite=1, held until MemReady.
  - MEMWB: ResultSrc=01. ALUWB: ResultSrc=00. Both: Rd=1111 gives PCWrite=1, RegWrite=0; otherwise RegWrite=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=1.
- **ALUControl:**
  - In EXECUTER/EXECUTEI: cmd 0100→00 (ADD), 0010→01 (SUB), 0000→10 (AND), 1100→11 (ORR), any other cmd→00.
  - In all other states: 00.
- **ImmSrc and RegSrc:** ImmSrc=Op. RegSrc={Op==10, Op==01}. Both combinational in every state.
- **Flag update:** in EXECUTER/EXECUTEI with Funct[0]=1, N and Z load from ALUFlags at the closing edge. C and V load only when cmd is ADD or SUB.

## Timing
- **Reset:** asserting `reset` low immediately forces:
  - State=FETCH
  - Flags=0000
  - PCWrite, IRWrite, RegWrite, MemWrite=0 while reset is low.
- **Reset mid-instruction:** the instruction is aborted. The first cycle after release is FETCH.
- **Cycles per instruction with MemReady always 1:**
  - branch 3
  - data-processing 4
  - STR 4
  - LDR 5
  - squashed 2
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs stay stable while stalled.
- **Flag ordering:** flags written by instruction k are visible to the DECODE of instruction k+1. There is no same-cycle bypass.
- **Illegal state:** returns to FETCH within one cycle.

## Structure
- Package `mc_pkg` holds:
  - state enum
  - condition-code constants
  - ALUControl codes
  - mux-select constants
- Sub-module `cond_unit` holds the flag register and the CondEx evaluation. Its ports are clk, reset, Cond, ALUFlags, FlagW[1:0], CondEx, Flags.
- The FSM and decode logic stay in `mc_controller`.

## Test plan
- **Reset mid-MEMRD:** assert reset in MEMRD → State=0, Flags=0000 and all write enables 0 immediately. FETCH follows release.
- **ADD with S, then SUB without S:** ADDS with ALUFlags=0110 → Flags=0110 after ALUWB. Following SUB (S=0) with ALUFlags=1001 → Flags unchanged.
- **EQ branch, both outcomes:** with Z=1, Op=10, Cond=0000 → states 0,1,9 and PCWrite=1 in BRANCH. With Z=0, Cond=0000 → states 0,1,0 and no PCWrite in the squashed instruction.
- **LDR with stalls:** LDR with MemReady low 2 cycles in FETCH and 3 in MEMRD → 10 total cycles. IRWrite pulses once. RegWrite=1 only in MEMWB.
- **Write to PC:** data-processing with Rd=1111 → PCWrite=1 and RegWrite=0 in ALUWB.
- **Condition-code sweep:** all 16 Cond values against all 16 flag states. Execute/squash decisions match the table above, and 1111 is never executed.
